// File: rtl/wb_master_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: bus widths,
// default abort timeout and FSM state encoding.
package wb_master_arbiter_pkg;

  localparam int WB_AddrBus   = 32;
  localparam int WB_DataBus   = 32;
  localparam int WB_SelectBus = 4;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter between an instruction-fetch master (m0) and a data
// master (m1) onto one Wishbone slave port, with a per-grant ack timeout.
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WB_AddrBus-1:0]   m0_addr_i,
  input  logic [WB_DataBus-1:0]   m0_data_i,
  input  logic                    m0_we_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  input  logic [WB_SelectBus-1:0] m0_sel_i,
  output logic [WB_DataBus-1:0]   m0_data_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic [WB_AddrBus-1:0]   m1_addr_i,
  input  logic [WB_DataBus-1:0]   m1_data_i,
  input  logic                    m1_we_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  input  logic [WB_SelectBus-1:0] m1_sel_i,
  output logic [WB_DataBus-1:0]   m1_data_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [WB_AddrBus-1:0]   s_addr_o,
  output logic [WB_DataBus-1:0]   s_data_o,
  output logic [WB_SelectBus-1:0] s_sel_o,
  output logic                    s_we_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  input  logic [WB_DataBus-1:0]   s_data_i,
  input  logic                    s_ack_i,
  output logic [1:0]              grant_o
);

  arb_state_e  state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;

  logic req0, req1, timeout, own_cyc;

  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign timeout = (cnt_q == TIMEOUT_CYCLES - 16'd1);
  assign own_cyc = (state_q == GRANT1) ? m1_cyc_i : m0_cyc_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 && req1)  state_d = last_q ? GRANT0 : GRANT1;
        else if (req0)     state_d = GRANT0;
        else if (req1)     state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        // Completion, master abort and timeout all release the bus the same way.
        if (s_ack_i || !own_cyc || timeout) begin
          state_d = IDLE;
          last_d  = (state_q == GRANT1);
          cnt_d   = '0;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output mux keyed on registered state only. cyc/stb are dropped on the
  // timeout cycle from the counter alone, so there is no s_ack_i -> s_cyc_o path.
  always_comb begin
    s_addr_o  = '0;
    s_data_o  = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_stb_o   = 1'b0;
    s_cyc_o   = 1'b0;
    m0_data_o = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    grant_o   = 2'b00;
    case (state_q)
      GRANT0: begin
        s_addr_o  = m0_addr_i;
        s_data_o  = m0_data_i;
        s_sel_o   = m0_sel_i;
        s_we_o    = m0_we_i;
        s_stb_o   = m0_stb_i & ~timeout;
        s_cyc_o   = m0_cyc_i & ~timeout;
        m0_data_o = s_data_i;
        m0_ack_o  = s_ack_i;
        m0_err_o  = timeout & ~s_ack_i & m0_cyc_i;
        grant_o   = 2'b01;
      end
      GRANT1: begin
        s_addr_o  = m1_addr_i;
        s_data_o  = m1_data_i;
        s_sel_o   = m1_sel_i;
        s_we_o    = m1_we_i;
        s_stb_o   = m1_stb_i & ~timeout;
        s_cyc_o   = m1_cyc_i & ~timeout;
        m1_data_o = s_data_i;
        m1_ack_o  = s_ack_i;
        m1_err_o  = timeout & ~s_ack_i & m1_cyc_i;
        grant_o   = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter with an 8-cycle timeout.
module tb_wb_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic        m0_we_i, m0_stb_i, m0_cyc_i, m1_we_i, m1_stb_i, m1_cyc_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_data_o, m1_data_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i;
  logic [1:0]  grant_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_we_i(m0_we_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_sel_i(m0_sel_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_we_i(m1_we_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_sel_i(m1_sel_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_addr_i = '0; m0_data_i = '0; m0_we_i = 0; m0_stb_i = 0; m0_cyc_i = 0; m0_sel_i = '0;
    m1_addr_i = '0; m1_data_i = '0; m1_we_i = 0; m1_stb_i = 0; m1_cyc_i = 0; m1_sel_i = '0;
    s_data_i = 32'hA5A5_A5A5; s_ack_i = 0;
    #12;
    chk("rst_s_cyc", 32'(s_cyc_o), 0);
    chk("rst_s_stb", 32'(s_stb_o), 0);
    chk("rst_s_addr", s_addr_o, 0);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_m0_ack", 32'(m0_ack_o), 0);
    chk("rst_m0_data", m0_data_o, 0);
    chk("rst_m1_err", 32'(m1_err_o), 0);
    rst = 1'b0;
    tick();

    // Single m0 read of 0x40, slave acks in the second grant cycle.
    m0_addr_i = 32'h0000_0040; m0_sel_i = 4'hF; m0_cyc_i = 1; m0_stb_i = 1;
    #1 chk("t1_req_cycle_cyc", 32'(s_cyc_o), 0);
    tick();
    chk("t1_cyc", 32'(s_cyc_o), 1);
    chk("t1_addr", s_addr_o, 32'h0000_0040);
    chk("t1_sel", 32'(s_sel_o), 32'hF);
    chk("t1_grant", 32'(grant_o), 32'h1);
    tick();
    s_ack_i = 1; s_data_i = 32'h1234_5678;
    #1;
    chk("t1_m0_ack", 32'(m0_ack_o), 1);
    chk("t1_m0_data", m0_data_o, 32'h1234_5678);
    chk("t1_m1_ack", 32'(m1_ack_o), 0);
    chk("t1_m1_data", m1_data_o, 0);
    chk("t1_m1_err", 32'(m1_err_o), 0);
    tick();
    s_ack_i = 0;
    chk("t1_idle_grant", 32'(grant_o), 0);

    // Fairness: both masters hold requests, last served was m0.
    m1_addr_i = 32'h0000_1000; m1_sel_i = 4'h3;
    m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    chk("t3_g1", 32'(grant_o), 32'h2);
    chk("t3_g1_addr", s_addr_o, 32'h0000_1000);
    s_ack_i = 1; #1;
    chk("t3_g1_m1_ack", 32'(m1_ack_o), 1);
    chk("t3_g1_m0_ack", 32'(m0_ack_o), 0);
    tick(); s_ack_i = 0;
    chk("t3_idle1", 32'(grant_o), 0);
    tick();
    chk("t3_g2", 32'(grant_o), 32'h1);
    s_ack_i = 1; #1;
    chk("t3_g2_m0_ack", 32'(m0_ack_o), 1);
    tick(); s_ack_i = 0;
    chk("t3_idle2", 32'(grant_o), 0);
    tick();
    chk("t3_g3", 32'(grant_o), 32'h2);
    s_ack_i = 1; #1;
    tick(); s_ack_i = 0;
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    chk("t3_idle3", 32'(grant_o), 0);
    tick();

    // Tie straight after reset: m0 first, then m1 after one idle cycle.
    rst = 1; #1 rst = 0;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    chk("t2_first", 32'(grant_o), 32'h1);
    s_ack_i = 1; #1;
    tick(); s_ack_i = 0;
    m0_cyc_i = 0; m0_stb_i = 0;
    chk("t2_idle", 32'(grant_o), 0);
    tick();
    chk("t2_second", 32'(grant_o), 32'h2);
    s_ack_i = 1; #1;
    tick(); s_ack_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0;

    // Timeout: m1 writes to an unmapped address, no ack ever comes.
    m1_addr_i = 32'hDEAD_0000; m1_data_i = 32'hCAFE_F00D; m1_we_i = 1;
    m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    chk("t4_grant", 32'(grant_o), 32'h2);
    chk("t4_we", 32'(s_we_o), 1);
    chk("t4_wdata", s_data_o, 32'hCAFE_F00D);
    for (int i = 0; i < 7; i++) begin
      chk("t4_no_err", 32'(m1_err_o), 0);
      chk("t4_cyc_held", 32'(s_cyc_o), 1);
      tick();
    end
    chk("t4_err", 32'(m1_err_o), 1);
    chk("t4_err_cyc", 32'(s_cyc_o), 0);
    chk("t4_err_stb", 32'(s_stb_o), 0);
    chk("t4_m0_err", 32'(m0_err_o), 0);
    tick();
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
    chk("t4_idle", 32'(grant_o), 0);
    chk("t4_err_gone", 32'(m1_err_o), 0);

    // Ack while idle is ignored.
    s_ack_i = 1; #1;
    chk("idle_ack_m0", 32'(m0_ack_o), 0);
    chk("idle_ack_m1", 32'(m1_ack_o), 0);
    tick(); s_ack_i = 0;
    chk("idle_ack_grant", 32'(grant_o), 0);

    // Master abort: m0 drops cyc in its second grant cycle.
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    chk("t5_grant", 32'(grant_o), 32'h1);
    tick();
    m0_cyc_i = 0; #1;
    chk("t5_cyc_drop", 32'(s_cyc_o), 0);
    chk("t5_ack", 32'(m0_ack_o), 0);
    chk("t5_err", 32'(m0_err_o), 0);
    tick();
    m0_stb_i = 0;
    chk("t5_idle", 32'(grant_o), 0);
    chk("t5_ack_after", 32'(m0_ack_o), 0);

    // Reset during a grant to m1.
    m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    chk("t6_cyc", 32'(s_cyc_o), 1);
    s_ack_i = 1;
    #1 rst = 1;
    #1;
    chk("t6_cyc_rst", 32'(s_cyc_o), 0);
    chk("t6_grant_rst", 32'(grant_o), 0);
    chk("t6_m1_ack_rst", 32'(m1_ack_o), 0);
    chk("t6_m0_ack_rst", 32'(m0_ack_o), 0);
    s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    #1 rst = 0;
    tick();
    chk("t6_post_idle", 32'(grant_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16'd255, meaning the cycles a granted transfer may wait for s_ack_i before abort.
REQ-002 The block SHALL have a single clock, with port clk  input  1  rising-edge system clock.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have ports m0_addr_i/m0_data_i  input  32 each  instruction-fetch master address and write data.
REQ-005 The block SHALL have ports m0_we_i, m0_stb_i, m0_cyc_i  input  1 each, and m0_sel_i  input  4  master-0 Wishbone controls.
REQ-006 The block SHALL have ports m0_data_o  output  32, and m0_ack_o, m0_err_o  output  1 each  master-0 read data, completion and abort.
REQ-007 The block SHALL have port group m1_* (data master), identical in direction and width to m0_*.
REQ-008 The block SHALL have ports s_addr_o/s_data_o  output  32 each, s_sel_o  output  4, and s_we_o, s_stb_o, s_cyc_o  output  1 each  toward bus decoder.
REQ-009 The block SHALL have ports s_data_i  input  32 and s_ack_i  input  1  from bus decoder.
REQ-010 The block SHALL have port grant_o  output  2  current owner, one-hot {m1,m0}, 2'b00 when idle (debug).

Function
REQ-011 The block SHALL implement an FSM with states IDLE, GRANT0 and GRANT1, plus a 1-bit last_served register and a 16-bit wait counter.
REQ-012 A request on master n SHALL be mn_cyc_i & mn_stb_i.
REQ-013 In IDLE with exactly one request, the FSM SHALL move to that master's GRANT state on the next edge.
REQ-014 In IDLE with both requests, the FSM SHALL grant the master not equal to last_served (round-robin).
REQ-015 Arbitration latency SHALL be exactly one cycle from request to s_cyc_o/s_stb_o assertion.
REQ-016 In GRANTn, s_addr_o, s_data_o, s_sel_o, s_we_o, s_stb_o and s_cyc_o SHALL combinationally follow master n.
REQ-017 When not granted, all s_* outputs SHALL be 0.
REQ-018 In GRANTn, mn_ack_o SHALL equal s_ack_i and mn_data_o SHALL equal s_data_i in the same cycle (zero-latency return).
REQ-019 The non-granted master SHALL see ack=0, err=0 and data_o=32'h0.
REQ-020 On s_ack_i in GRANTn, the FSM SHALL go to IDLE, set last_served=n and clear the counter.
REQ-021 A re-request by the same master SHALL therefore re-arbitrate and lose to a pending other master.
REQ-022 The wait counter SHALL increment on each GRANT cycle without s_ack_i and SHALL saturate rather than wrap.
REQ-023 When the counter equals TIMEOUT_CYCLES-1 without ack, the block SHALL assert mn_err_o for one cycle with s_cyc_o/s_stb_o forced to 0 that cycle, then go to IDLE with last_served=n.
REQ-024 If mn_cyc_i drops while in GRANTn (master abort), the FSM SHALL go to IDLE next edge with no ack or err to the master, and last_served=n.
REQ-025 If s_ack_i and the timeout coincide, ack SHALL win and err SHALL stay 0.
REQ-026 s_ack_i arriving in IDLE SHALL be ignored.
REQ-027 grant_o SHALL be registered state decode: GRANT0=2'b01, GRANT1=2'b10.

Reset
REQ-028 Asserting rst SHALL asynchronously force state=IDLE, last_served=1 (so m0 wins the first tie), counter=0, all s_* outputs 0, all m*_ack_o/err_o 0, m*_data_o 0, and grant_o=2'b00.
REQ-029 Reset mid-transaction SHALL drop s_cyc_o immediately, with no completion signalled to either master.

Structure
REQ-030 FSM state encodings, port widths (WB_AddrBus 32, WB_DataBus 32, WB_SelectBus 4) and the default TIMEOUT_CYCLES SHALL live in the shared defines file.
REQ-031 The block SHALL be a single module with no sub-modules; the combinational output mux SHALL be selected by registered state only.

Verification
REQ-032 The bench SHALL cover a single request: m0 reads 0x0000_0040, slave acks after 2 cycles with 0x1234_5678 -> s_cyc_o high 1 cycle after request, m0_ack_o=1 with m0_data_o=0x1234_5678 in the ack cycle, m1 outputs 0.
REQ-033 The bench SHALL cover a tie after reset: m0 and m1 request together -> m0 granted first (grant_o=01), then m1 (grant_o=10) after one IDLE cycle.
REQ-034 The bench SHALL cover fairness: m1 requests continuously with m0 also pending -> grants alternate 10,01,10.
REQ-035 The bench SHALL cover timeout: TIMEOUT_CYCLES=8, m1 write to unmapped address, s_ack_i never asserts -> m1_err_o pulses 1 cycle, 8 cycles after grant, then IDLE.
REQ-036 The bench SHALL cover master abort: m0 drops cyc in cycle 2 of GRANT0 -> IDLE next edge, m0_ack_o/m0_err_o stay 0.
REQ-037 The bench SHALL cover reset mid-transfer: rst asserted during GRANT1 -> s_cyc_o=0 and grant_o=00 without waiting for a clock edge.
